// File: rtl/data_mem_responder_if.sv
// Data-port bus between the MIPS core (master) and the data memory (slave).
// Read data is combinational; there is no wait state on this bus.
interface data_mem_responder_if;
   logic [31:0] data_address;
   logic        data_read;
   logic        data_write;
   logic [3:0]  byte_enable;
   logic [31:0] data_writedata;
   logic [31:0] data_readdata;

   modport master (
      output data_address, data_read, data_write, byte_enable, data_writedata,
      input  data_readdata
   );

   modport slave (
      input  data_address, data_read, data_write, byte_enable, data_writedata,
      output data_readdata
   );
endinterface : data_mem_responder_if

// File: rtl/data_mem_responder.sv
// Zero-wait-state data memory for the Harvard MIPS core.
// Writes are posted into a one-entry buffer that drains on the next edge.
// Reads merge the array word with any pending bytes for the same word.
// A sticky addr_error flags out-of-window or empty-lane accesses.
// Optional read/write statistics counters: define DATA_MEM_STATS_EN.
module data_mem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
   parameter int          DEPTH_WORDS = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_enable,
   data_mem_responder_if.slave bus,
   output logic                addr_error
`ifdef DATA_MEM_STATS_EN
   ,
   output logic [31:0]         read_count,
   output logic [31:0]         write_count
`endif
);

   localparam int          IDX_W   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] BASE33  = {1'b0, ADDR_BASE};
   localparam logic [32:0] LIMIT33 = BASE33 + 33'(4 * DEPTH_WORDS);

   logic [32:0]      addr33;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic             wr_accept;
   logic             err_event;

   logic             pend_valid_q, pend_valid_d;
   logic [IDX_W-1:0] pend_idx_q,   pend_idx_d;
   logic [3:0]       pend_be_q,    pend_be_d;
   logic [31:0]      pend_data_q,  pend_data_d;
   logic             err_q,        err_d;

   logic [31:0]      mem_q [DEPTH_WORDS];

   // Window decode in 33 bits so the upper limit cannot wrap past 2^32.
   assign addr33    = {1'b0, bus.data_address};
   assign in_range  = (addr33 >= BASE33) && (addr33 < LIMIT33);
   assign idx       = IDX_W'((addr33 - BASE33) >> 2);
   assign wr_accept = clk_enable && bus.data_write && in_range
                      && (bus.byte_enable != 4'b0000);
   assign err_event = clk_enable
                      && (((bus.data_read || bus.data_write) && !in_range)
                          || (bus.data_write && (bus.byte_enable == 4'b0000)));

   // Read path: array word with pending lanes for the same word forwarded on top.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      bus.data_readdata = 32'h0;
      if (bus.data_read && in_range) begin
         bus.data_readdata = mem_q[idx];
         for (int i = 0; i < 4; i++) begin
            if (pend_valid_q && (pend_idx_q == idx) && pend_be_q[i]) begin
               bus.data_readdata[8*i +: 8] = pend_data_q[8*i +: 8];
            end
         end
      end
   end

   // Next state of the write buffer and the sticky error flag.
   always_comb begin
      pend_valid_d = 1'b0;
      pend_idx_d   = pend_idx_q;
      pend_be_d    = pend_be_q;
      pend_data_d  = pend_data_q;
      err_d        = err_q | err_event;
      if (wr_accept) begin
         pend_valid_d = 1'b1;
         pend_idx_d   = idx;
         pend_be_d    = bus.byte_enable;
         pend_data_d  = bus.data_writedata;
      end
   end

   // Write-buffer and error registers; reset drops any pending write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
         pend_be_q    <= 4'b0000;
         pend_data_q  <= 32'h0;
         err_q        <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         pend_valid_q <= pend_valid_d;
         pend_idx_q   <= pend_idx_d;
         pend_be_q    <= pend_be_d;
         pend_data_q  <= pend_data_d;
         err_q        <= err_d;
      end
   end

   // Drain the pending entry into the array under its byte mask.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset so it maps onto plain RAM; contents survive reset.
      if (pend_valid_q) begin
         for (int i = 0; i < 4; i++) begin
            if (pend_be_q[i]) begin
               mem_q[pend_idx_q][8*i +: 8] <= pend_data_q[8*i +: 8];
            end
         end
      end
   end

   assign addr_error = err_q;

`ifdef DATA_MEM_STATS_EN
   logic        rd_accept;
   logic [31:0] read_count_q, write_count_q;

   assign rd_accept = clk_enable && bus.data_read && in_range;

   // Saturating counters of accepted reads and writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_count_q  <= 32'h0;
         write_count_q <= 32'h0;
      end else begin
         if (rd_accept && (read_count_q != 32'hFFFF_FFFF)) begin
            read_count_q <= read_count_q + 32'd1;
         end
         if (wr_accept && (write_count_q != 32'hFFFF_FFFF)) begin
            write_count_q <= write_count_q + 32'd1;
         end
      end
   end

   assign read_count  = read_count_q;
   assign write_count = write_count_q;
`endif

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder (1024 words at 0x1000).
module tb_data_mem_responder;

   typedef struct {
      logic        ce;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic clk_enable;
   logic addr_error;
`ifdef DATA_MEM_STATS_EN
   logic [31:0] read_count;
   logic [31:0] write_count;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   vec_t vecs[$];

   data_mem_responder_if bus ();

   data_mem_responder #(
      .ADDR_BASE   (32'h0000_1000),
      .DEPTH_WORDS (1024)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .bus        (bus.slave),
      .addr_error (addr_error)
`ifdef DATA_MEM_STATS_EN
      ,
      .read_count  (read_count),
      .write_count (write_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ce, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata);
      clk_enable          = ce;
      bus.data_read       = rd;
      bus.data_write      = wr;
      bus.data_address    = addr;
      bus.byte_enable     = be;
      bus.data_writedata  = wdata;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic ce, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata);
      vec_t v;
      v.ce = ce; v.rd = rd; v.wr = wr; v.addr = addr; v.be = be;
      v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = 1'b0;
      return v;
   endfunction

   initial begin
      // Preload words, then forwarding, merge, same-cycle read/write, clk_enable low.
      vecs.push_back(mk(1, 0, 1, 32'h1000, 4'hF, 32'hA5A5_A5A5, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h1FFC, 4'hF, 32'h0BAD_F00D, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h1008, 4'hF, 32'h1122_3344, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h100C, 4'hF, 32'h0000_0000, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h1010, 4'hF, 32'h1234_5678, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h1014, 4'hF, 32'h0000_0000, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h1004, 4'hF, 32'hDEAD_BEEF, 32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h1004, 4'h0, 32'h0,         32'hDEAD_BEEF));
      vecs.push_back(mk(1, 0, 0, 32'h1004, 4'h0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h1004, 4'h0, 32'h0,         32'hDEAD_BEEF));
      vecs.push_back(mk(1, 0, 1, 32'h1008, 4'h2, 32'h0000_AA00, 32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h1008, 4'h0, 32'h0,         32'h1122_AA44));
      vecs.push_back(mk(1, 1, 1, 32'h100C, 4'hF, 32'h0000_0055, 32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h100C, 4'h0, 32'h0,         32'h0000_0055));
      vecs.push_back(mk(1, 1, 0, 32'h1008, 4'h0, 32'h0,         32'h1122_AA44));
      vecs.push_back(mk(0, 1, 1, 32'h1010, 4'hF, 32'hFFFF_FFFF, 32'h1234_5678));
      vecs.push_back(mk(1, 1, 0, 32'h1010, 4'h0, 32'h0,         32'h1234_5678));
      vecs.push_back(mk(0, 1, 0, 32'h0FFC, 4'h0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h1014, 4'h3, 32'h0000_BBBB, 32'h0));
      vecs.push_back(mk(1, 0, 1, 32'h1014, 4'hC, 32'hCCCC_0000, 32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h1014, 4'h0, 32'h0,         32'hCCCC_BBBB));
      vecs.push_back(mk(1, 0, 0, 32'h1014, 4'h0, 32'h0,         32'h0));
      vecs.push_back(mk(1, 1, 0, 32'h1014, 4'h0, 32'h0,         32'hCCCC_BBBB));
      vecs.push_back(mk(1, 1, 0, 32'h1FFC, 4'h0, 32'h0,         32'h0BAD_F00D));
      vecs.push_back(mk(1, 1, 0, 32'h1000, 4'h0, 32'h0,         32'hA5A5_A5A5));
      vecs.push_back(mk(1, 0, 0, 32'h1000, 4'h0, 32'h0,         32'h0));

      reset = 1'b0;
      drive(1, 0, 0, 32'h1000, 4'h0, 32'h0);
      repeat (3) @(negedge clk);
      check("reset_err", {31'h0, addr_error}, 32'h0);
      check("reset_rdata_idle", bus.data_readdata, 32'h0);
      reset = 1'b1;
      step();

      foreach (vecs[i]) begin
         drive(vecs[i].ce, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
         #1;
         check($sformatf("vec%0d_rdata", i), bus.data_readdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), {31'h0, addr_error}, {31'h0, vecs[i].exp_err});
         step();
      end

      // Out-of-window read sets the sticky flag at the first edge.
      drive(1, 1, 0, 32'h0FFC, 4'h0, 32'h0);
      #1;
      check("oow_read_rdata", bus.data_readdata, 32'h0);
      check("oow_read_err_pre", {31'h0, addr_error}, 32'h0);
      step();
      check("oow_read_err_post", {31'h0, addr_error}, 32'h1);

      // Write at the window limit aliases idx 0 if decoded wrongly; word 0 must stay intact.
      drive(1, 0, 1, 32'h2000, 4'hF, 32'hFFFF_FFFF);
      step();
      drive(1, 0, 0, 32'h1000, 4'h0, 32'h0);
      step();
      drive(1, 1, 0, 32'h1000, 4'h0, 32'h0);
      #1;
      check("oow_write_word0", bus.data_readdata, 32'hA5A5_A5A5);
      check("oow_write_err", {31'h0, addr_error}, 32'h1);

      // Reset clears the sticky flag.
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("err_cleared_by_reset", {31'h0, addr_error}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // A pending write caught by reset is discarded.
      drive(1, 0, 1, 32'h1010, 4'hF, 32'hCAFE_F00D);
      @(posedge clk);
      #1;
      drive(1, 1, 0, 32'h1010, 4'h0, 32'h0);
      #1;
      check("pend_fwd_before_reset", bus.data_readdata, 32'hCAFE_F00D);
      reset = 1'b0;
      #1;
      check("read_during_reset", bus.data_readdata, 32'h1234_5678);
      @(negedge clk);
      reset = 1'b1;
      step();
      check("pend_discarded", bus.data_readdata, 32'h1234_5678);

      // Write with an empty lane mask is flagged and never lands.
      drive(1, 0, 1, 32'h1010, 4'h0, 32'hFFFF_FFFF);
      step();
      check("be0_err", {31'h0, addr_error}, 32'h1);
      drive(1, 1, 0, 32'h1010, 4'h0, 32'h0);
      step();
      check("be0_no_write", bus.data_readdata, 32'h1234_5678);

`ifdef DATA_MEM_STATS_EN
      reset = 1'b0;
      #1;
      check("stats_reset_rd", read_count, 32'd0);
      check("stats_reset_wr", write_count, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 32'h1000 + 32'(4 * i), 4'h0, 32'h0);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 1, 32'h1020 + 32'(4 * i), 4'hF, 32'h0);
         step();
      end
      drive(1, 1, 1, 32'h1030, 4'hF, 32'h0);
      step();
      drive(0, 1, 1, 32'h1034, 4'hF, 32'h0);
      step();
      check("stats_read_count", read_count, 32'd4);
      check("stats_write_count", write_count, 32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_data_mem_responder

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory target for the Harvard MIPS core's data port.
- Accepts data_read/data_write with byte_enable from the CPU and returns data_readdata in the same cycle, as the core requires (the interface has no wait state).
- Writes are posted into a one-entry write buffer that drains to the word array on the next edge; reads forward from the buffer.
- Flags out-of-window and malformed accesses with a sticky error bit for testbench and halt logic.

Parameters:
- ADDR_BASE, 32'h0000_1000, byte address of word 0 of the array.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, min 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clk_enable  input  1  when low, no new access is accepted; buffer still drains.
- data_address  input  32  byte address from CPU; bits [1:0] ignored.
- data_read  input  1  read request, combinational.
- data_write  input  1  write request, sampled at rising edge.
- byte_enable  input  4  lane mask; bit i selects bits [8i+7:8i].
- data_writedata  input  32  write data, lane-aligned.
- data_readdata  output  32  read data, combinational.
- addr_error  output  1  sticky access-error flag.

Behaviour:
- Window:
  - in_range = (data_address >= ADDR_BASE) && (data_address < ADDR_BASE + 4*DEPTH_WORDS).
  - idx = (data_address - ADDR_BASE) >> 2, truncated to log2(DEPTH_WORDS) bits.
  - Arithmetic is 33-bit so that ADDR_BASE + 4*DEPTH_WORDS cannot wrap past 2^32.
- Read path (combinational, zero latency):
  - If data_read && in_range: data_readdata = mem[idx], with each lane replaced by pend_data's lane where pend_valid && pend_idx==idx && pend_be[i].
  - Otherwise data_readdata = 32'h0.
  - byte_enable is not used on reads; the CPU extracts bytes itself.
- Write buffer:
  - State: pend_valid, pend_idx, pend_be[3:0], pend_data[31:0].
  - Every rising edge, first: if pend_valid, commit pend_data to mem[pend_idx] under pend_be.
  - Then: if clk_enable && data_write && in_range && byte_enable!=0, load the buffer with {1, idx, byte_enable, data_writedata}; else pend_valid <= 0.
  - Net effect: write visible to forwarded reads on the next cycle; in array storage 2 edges after the request.
- Simultaneous events:
  - data_read && data_write same cycle: read returns the pre-write value (old array merged with old buffer). The write is posted normally.
  - A new write to the same idx as the draining entry: drain commits first, new entry loads; no byte lost.
  - Back-to-back writes sustain 1 per cycle with no stall.
- addr_error: set at the edge when clk_enable and any of:
  - (data_read || data_write) && !in_range;
  - data_write && byte_enable==4'b0.
  - Sticky; cleared only by reset. Rejected writes never modify memory.
- Reset (async assert, sync deassert by the user):
  - pend_valid=0, pend_idx=0, pend_be=0, pend_data=0, addr_error=0.
  - Array contents are not cleared.
  - A pending write at assertion is discarded, never committed.
  - data_readdata follows the combinational rule throughout reset.
- clk_enable low: reads still answer combinationally; no capture; no error update; pending entry still drains.

Optional Feature:
- Macro: DATA_MEM_STATS_EN.
- Defined:
  - Adds output read_count [31:0] and output write_count [31:0].
  - Incremented at each edge with clk_enable and an accepted, in-range data_read / data_write respectively.
  - Saturate at 32'hFFFF_FFFF; reset to 0.
  - A simultaneous read+write increments both.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Write 32'hDEADBEEF, be=4'hF, to 0x1004; next cycle read 0x1004 -> 32'hDEADBEEF (forwarded). Two cycles later with no writes, read -> 32'hDEADBEEF (from array).
- Word 0x1008 = 32'h11223344; write be=4'b0010, data 32'h0000AA00; next cycle read -> 32'h1122AA44.
- Same-cycle read+write to 0x100C (old 32'h0, new 32'h55): read returns 32'h0; the following cycle returns 32'h55.
- Read 0x0FFC, then write to 0x1000+4*DEPTH_WORDS -> data_readdata 0, addr_error 1 from the first edge; memory unchanged. Assert reset -> addr_error 0.
- Write 32'hCAFEF00D to 0x1010, assert reset before the next edge, release -> read 0x1010 returns the prior value (pending write discarded). Write with be=0 sets addr_error.
- With DATA_MEM_STATS_EN: 3 reads, 2 writes, 1 read+write cycle, 1 cycle with clk_enable low -> read_count=4, write_count=3.
